// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared encodings for the seven-segment scan controller: game states and
// active-low glyphs, bit order {g,f,e,d,c,b,a}.
package ssd_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GO   = 2'b01,
      ST_HOLD = 2'b10,
      ST_END  = 2'b11
   } game_st_t;

   localparam logic [6:0] G_I  = 7'h4F;
   localparam logic [6:0] G_d  = 7'h21;
   localparam logic [6:0] G_L  = 7'h47;
   localparam logic [6:0] G_E  = 7'h06;
   localparam logic [6:0] G_G  = 7'h42;
   localparam logic [6:0] G_o  = 7'h23;
   localparam logic [6:0] G_H  = 7'h09;
   localparam logic [6:0] G_n  = 7'h2B;
   localparam logic [6:0] G_SP = 7'h7F;

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Game-side bundle of the scan controller: state/blank in, display pins out.
interface ssd_scan_ctrl_if;
   logic [1:0] state;
   logic       blank;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       frame_done;

   modport master (output state, blank, input seg, dp, an, frame_done);
   modport slave  (input state, blank, output seg, dp, an, frame_done);
endinterface

// File: rtl/ssd_scan_ctrl_glyph_lut.sv
// Message table: {state, digit} -> active-low segment pattern, digit 0 leftmost.
module ssd_scan_ctrl_glyph_lut
   import ssd_scan_ctrl_pkg::*;
(
   input  game_st_t   i_state,
   input  logic [1:0] i_dig,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = G_SP;
      case (i_state)
         ST_IDLE: begin
            case (i_dig)
               2'd0:    o_seg = G_I;
               2'd1:    o_seg = G_d;
               2'd2:    o_seg = G_L;
               default: o_seg = G_E;
            endcase
         end
         ST_GO: begin
            case (i_dig)
               2'd0:    o_seg = G_G;
               2'd1:    o_seg = G_o;
               default: o_seg = G_SP;
            endcase
         end
         ST_HOLD: begin
            case (i_dig)
               2'd0:    o_seg = G_H;
               2'd1:    o_seg = G_o;
               2'd2:    o_seg = G_L;
               default: o_seg = G_d;
            endcase
         end
         default: begin
            case (i_dig)
               2'd0:    o_seg = G_E;
               2'd1:    o_seg = G_n;
               2'd2:    o_seg = G_d;
               default: o_seg = G_SP;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scanner: prescaled digit rotation, per-frame state
// latch, blinking END message and registered anode/segment drive.
module ssd_scan_ctrl
   import ssd_scan_ctrl_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 16,
   parameter int BLINK_FRAMES = 125
) (
   input  logic           clk,
   input  logic           rst_n,
   ssd_scan_ctrl_if.slave io_bus
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD_CYCLES);
   localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

   logic [DIV_W-1:0] r_div_cnt;
   logic [1:0]       r_dig_idx;
   game_st_t         r_cur_state;
   logic [BLK_W-1:0] r_blink_cnt;
   logic             r_blink_on;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;

   logic             w_slot_end;
   logic             w_frame_end;
   logic             w_dark;
   logic [3:0]       w_an_sel;
   logic [6:0]       w_glyph;
   game_st_t         w_state_in;

   assign w_slot_end  = (r_div_cnt == DIV_LAST);
   assign w_frame_end = w_slot_end && (r_dig_idx == 2'd3);
   assign w_state_in  = game_st_t'(io_bus.state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
         r_dig_idx <= '0;
      end else if (w_slot_end) begin
         r_div_cnt <= '0;
         r_dig_idx <= r_dig_idx + 2'd1;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   // State is only taken at frame boundaries so a message never mixes two states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_state <= ST_IDLE;
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (w_frame_end) begin
         r_cur_state <= w_state_in;
         if (w_state_in != r_cur_state) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
         end else if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
         end
      end
   end

   ssd_scan_ctrl_glyph_lut u_glyph (
      .i_state (r_cur_state),
      .i_dig   (r_dig_idx),
      .o_seg   (w_glyph)
   );

   // Guard window at each slot start keeps the previous digit's pattern from ghosting.
   assign w_dark   = io_bus.blank
                  || (r_div_cnt < GUARD_END)
                  || ((r_cur_state == ST_END) && !r_blink_on);
   assign w_an_sel = ~(4'b1000 >> r_dig_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= 4'b1111;
         r_seg <= G_SP;
      end else if (w_dark) begin
         r_an  <= 4'b1111;
         r_seg <= G_SP;
      end else begin
         r_an  <= w_an_sel;
         r_seg <= w_glyph;
      end
   end

   assign io_bus.an         = r_an;
   assign io_bus.seg        = r_seg;
   assign io_bus.dp         = 1'b1;
   assign io_bus.frame_done = w_frame_end;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed scenarios plus random state/blank/reset
// traffic compared cycle by cycle against a frame-level display model.
module tb_ssd_scan_ctrl;

   localparam int RD    = 4;
   localparam int GC    = 1;
   localparam int BF    = 2;
   localparam int FRAME = 4 * RD;

   logic clk = 1'b0;
   logic rst_n;

   ssd_scan_ctrl_if bus ();

   ssd_scan_ctrl #(
      .REFRESH_DIV  (RD),
      .GUARD_CYCLES (GC),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   string      msg [4];
   logic [1:0] t_state;
   logic       t_blank;
   int         m_pos;
   int         m_cur;
   int         m_frames;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [6:0] glyph(input byte c);
      case (c)
         "I":     return 7'h4F;
         "d":     return 7'h21;
         "L":     return 7'h47;
         "E":     return 7'h06;
         "G":     return 7'h42;
         "o":     return 7'h23;
         "H":     return 7'h09;
         "n":     return 7'h2B;
         default: return 7'h7F;
      endcase
   endfunction

   // Expected display after the coming edge, then advance the frame-level model.
   task automatic model_edge(output logic [3:0] ea, output logic [6:0] es);
      int div;
      int dig;
      bit vis;
      div = m_pos % RD;
      dig = m_pos / RD;
      vis = ((m_frames / BF) % 2) == 0;
      ea  = 4'hF;
      es  = 7'h7F;
      if (!(t_blank || div < GC || (m_cur == 3 && !vis))) begin
         ea[3-dig] = 1'b0;
         es        = glyph(msg[m_cur].getc(dig));
      end
      if (m_pos == FRAME - 1) begin
         if (int'(t_state) != m_cur) m_frames = 0;
         else                        m_frames++;
         m_cur = int'(t_state);
      end
      m_pos = (m_pos + 1) % FRAME;
   endtask

   // Entered and left just after a falling edge.
   task automatic tick();
      logic [3:0] ea;
      logic [6:0] es;
      bus.state = t_state;
      bus.blank = t_blank;
      #1;
      chk("frame_done", {31'd0, bus.frame_done}, {31'd0, m_pos == FRAME - 1});
      @(posedge clk);
      model_edge(ea, es);
      #1;
      chk("an", {28'd0, bus.an}, {28'd0, ea});
      chk("seg", {25'd0, bus.seg}, {25'd0, es});
      chk("dp", {31'd0, bus.dp}, 32'd1);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic run_to(input int p);
      for (int k = 0; k < FRAME && m_pos != p; k++) tick();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      #1;
      chk("rst_an", {28'd0, bus.an}, 32'hF);
      chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
      chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
      repeat (n) @(negedge clk);
      rst_n    = 1'b1;
      m_pos    = 0;
      m_cur    = 0;
      m_frames = 0;
   endtask

   initial begin
      msg[0] = "IdLE";
      msg[1] = "Go  ";
      msg[2] = "HoLd";
      msg[3] = "End ";
      t_state   = 2'b00;
      t_blank   = 1'b0;
      bus.state = 2'b00;
      bus.blank = 1'b0;
      rst_n     = 1'b1;
      #2;
      do_reset(3);

      // Idle scan
      run(2 * FRAME + 4);

      // 00 -> 01 while digit 1 is lit
      run_to(5);
      t_state = 2'b01;
      run(3 * FRAME);

      // END blinking, then HOLD mid-blink
      t_state = 2'b11;
      run(8 * FRAME);
      run_to(6);
      t_state = 2'b10;
      run(3 * FRAME);

      // blank pulse mid-frame
      run_to(3);
      t_blank = 1'b1;
      run(10);
      t_blank = 1'b0;
      run(2 * FRAME);

      // reset during digit 2
      run_to(9);
      do_reset(3);
      run(2 * FRAME);

      // state toggling every cycle
      for (int i = 0; i < 6 * FRAME; i++) begin
         t_state = (t_state == 2'b01) ? 2'b10 : 2'b01;
         tick();
      end

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(39) == 0)
            t_state = ($urandom_range(1) == 0) ? 2'b11 : 2'($urandom_range(3));
         if ($urandom_range(29) == 0)
            t_blank = ~t_blank;
         if ($urandom_range(499) == 0)
            do_reset(1 + $urandom_range(2));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
